// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer.
//   - default screen geometry (H_RES_DEFAULT x V_RES_DEFAULT)
//   - bus widths for addresses, coordinates and colors
//   - writer FSM state type
//   - FIFO entry layout (address + color)
package fb_pkg;

  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 480;

  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned COORD_X_W = 10;
  localparam int unsigned COORD_Y_W = 9;
  localparam int unsigned COLOR_W   = 9;

  localparam int unsigned FIFO_ENTRY_W = FB_ADDR_W + COLOR_W;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_FLUSH
  } fb_state_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOR_W-1:0]   color;
  } fifo_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding pending framebuffer writes.
// The oldest entry is kept in a dedicated head register so the consumer
// sees it straight from a flop.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i/wdata_i enqueue request and data (ignored when full)
//   pop_i          dequeue request (ignored when empty)
//   head_o         oldest entry (valid when !empty_o)
//   full_o/empty_o occupancy flags
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = FIFO_ENTRY_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [WIDTH-1:0] head_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rd_next = rd_ptr_q + PTR_W'(1);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; occupancy tracking makes stale contents unobservable.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_next;
      end
      count_q <= count_d;
      // Head refill: after a pop the next-oldest stored entry takes over;
      // an incoming entry becomes head only when nothing older remains.
      if (pop_ok && (count_q > CNT_ONE)) begin
        head_q <= mem_q[rd_next];
      end else if (push_ok && ((count_q == '0) || (pop_ok && (count_q == CNT_ONE)))) begin
        head_q <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: receives (x, y, color) pixel writes from overlay
// drawers, buffers them in a small FIFO, converts coordinates to linear
// addresses and commits them through a granted write port. Also fills the
// whole framebuffer with CLEAR_COLOR after reset and on clear_req.
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   pix_valid/pix_ready     pixel handshake
//   pix_x, pix_y, pix_color pixel coordinates and RGB 3:3:3 color
//   clear_req               single-cycle clear request (ignored unless running)
//   fb_we/fb_addr/fb_data   framebuffer write request, held until fb_grant
//   fb_grant                write taken this cycle when fb_we=1
//   busy                    clearing, flushing, or writes still queued
//   clip_count              saturating count of discarded out-of-range pixels
// Build option: FB_WRITER_CLIP_EN enables range checking and clip_count;
// without it pixels are never discarded and clip_count reads 0.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int unsigned         H_RES       = H_RES_DEFAULT,
  parameter int unsigned         V_RES       = V_RES_DEFAULT,
  parameter int unsigned         FIFO_DEPTH  = 4,
  parameter logic [COLOR_W-1:0]  CLEAR_COLOR = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [COORD_X_W-1:0] pix_x,
  input  logic [COORD_Y_W-1:0] pix_y,
  input  logic [COLOR_W-1:0]   pix_color,
  input  logic                 clear_req,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  input  logic                 fb_grant,
  output logic                 busy,
  output logic [7:0]           clip_count
);

  localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(H_RES * V_RES - 1);

  fb_state_e            state_q;
  logic [FB_ADDR_W-1:0] clr_cnt_q;

  fifo_entry_t wr_entry;
  fifo_entry_t head_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        in_range;
  logic        push;
  logic        pop;

  // Linear address, computed modulo 2^FB_ADDR_W; for 640 columns this
  // reduces to (y<<9) + (y<<7) + x.
  assign wr_entry.addr  = FB_ADDR_W'(pix_y) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(pix_x);
  assign wr_entry.color = pix_color;

  assign pix_ready = (state_q == S_RUN) && !fifo_full;
  assign accept    = pix_valid && pix_ready;
  assign push      = accept && in_range;
  assign pop       = (state_q != S_CLEAR) && !fifo_empty && fb_grant;

  assign fb_we   = (state_q == S_CLEAR) || !fifo_empty;
  assign fb_addr = (state_q == S_CLEAR) ? clr_cnt_q   : head_entry.addr;
  assign fb_data = (state_q == S_CLEAR) ? CLEAR_COLOR : head_entry.color;
  assign busy    = (state_q != S_RUN) || !fifo_empty;

`ifdef FB_WRITER_CLIP_EN
  logic [7:0] clip_q;

  assign in_range = ({1'b0, pix_x} < (COORD_X_W + 1)'(H_RES)) &&
                    ({1'b0, pix_y} < (COORD_Y_W + 1)'(V_RES));
  assign clip_count = clip_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      clip_q <= '0;
    end else if (accept && !in_range && (clip_q != '1)) begin
      clip_q <= clip_q + 8'd1;
    end
  end
`else
  assign in_range   = 1'b1;
  assign clip_count = '0;
`endif

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_ENTRY_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          if (fb_grant) begin
            if (clr_cnt_q == CLR_LAST) begin
              state_q   <= S_RUN;
              clr_cnt_q <= '0;
            end else begin
              clr_cnt_q <= clr_cnt_q + FB_ADDR_W'(1);
            end
          end
        end
        S_RUN: begin
          if (clear_req) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Queued pixels drain first so none are lost behind the clear.
          if (fifo_empty) begin
            state_q <= S_CLEAR;
          end
        end
        default: begin
          state_q <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomized bench for fb_pixel_writer against a queue-based reference model
// of the writer's observable behaviour (small screen to keep clears short).
`timescale 1ns/1ps
module tb_fb_pixel_writer;

  localparam int unsigned H     = 16;
  localparam int unsigned V     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TOTAL = H * V;
  localparam logic [8:0]  CLR_COLOR = 9'h0A5;

  logic        clock = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [8:0]  pix_color;
  logic        clear_req;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [8:0]  fb_data;
  logic        fb_grant;
  logic        busy;
  logic [7:0]  clip_count;

  always #5 clock = ~clock;

  fb_pixel_writer #(
    .H_RES       (H),
    .V_RES       (V),
    .FIFO_DEPTH  (DEPTH),
    .CLEAR_COLOR (CLR_COLOR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .clear_req  (clear_req),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_grant   (fb_grant),
    .busy       (busy),
    .clip_count (clip_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: screen is either being cleared (clear_pos pixels done),
  // draining for a clear, or accepting pixels; pending writes are a queue.
  bit          m_clearing;
  bit          m_flushing;
  int unsigned m_clear_pos;
  int unsigned m_clip;
  int unsigned q_addr[$];
  int unsigned q_col[$];

  task automatic model_reset();
    m_clearing  = 1'b1;
    m_flushing  = 1'b0;
    m_clear_pos = 0;
    m_clip      = 0;
    q_addr.delete();
    q_col.delete();
  endtask

  // One clock: drive inputs at the falling edge, compare outputs, then
  // advance the model by what the coming rising edge should do.
  task automatic step(input bit rst, input bit v, input int unsigned x, input int unsigned y,
                      input int unsigned c, input bit cr, input bit g, output bit acc);
    bit          exp_ready;
    bit          exp_we;
    bit          exp_busy;
    bit          was_empty;
    bit          keep;
    int unsigned exp_addr;
    int unsigned exp_data;
    @(negedge clock);
    reset     = rst;
    pix_valid = v;
    pix_x     = 10'(x);
    pix_y     = 9'(y);
    pix_color = 9'(c);
    clear_req = cr;
    fb_grant  = g;
    #1;
    exp_ready = !m_clearing && !m_flushing && (q_addr.size() < DEPTH);
    exp_we    = m_clearing || (q_addr.size() > 0);
    exp_busy  = m_clearing || m_flushing || (q_addr.size() > 0);
    check_eq("pix_ready", 32'(pix_ready), 32'(exp_ready));
    check_eq("fb_we", 32'(fb_we), 32'(exp_we));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("clip_count", 32'(clip_count), m_clip);
    if (exp_we) begin
      exp_addr = m_clearing ? m_clear_pos : q_addr[0];
      exp_data = m_clearing ? 32'(CLR_COLOR) : q_col[0];
      check_eq("fb_addr", 32'(fb_addr), exp_addr);
      check_eq("fb_data", 32'(fb_data), exp_data);
    end
    acc = v && exp_ready && !rst;
    if (rst) begin
      model_reset();
    end else if (m_clearing) begin
      if (g) begin
        m_clear_pos++;
        if (m_clear_pos == TOTAL) begin
          m_clearing  = 1'b0;
          m_clear_pos = 0;
        end
      end
    end else begin
      was_empty = (q_addr.size() == 0);
      if (g && !was_empty) begin
        void'(q_addr.pop_front());
        void'(q_col.pop_front());
      end
      if (acc) begin
`ifdef FB_WRITER_CLIP_EN
        keep = (x < H) && (y < V);
`else
        keep = 1'b1;
`endif
        if (keep) begin
          q_addr.push_back(((y % 512) * H + (x % 1024)) % (1 << 19));
          q_col.push_back(c % 512);
        end else if (m_clip < 255) begin
          m_clip++;
        end
      end
      if (m_flushing) begin
        if (was_empty) begin
          m_flushing = 1'b0;
          m_clearing = 1'b1;
        end
      end else if (cr) begin
        m_flushing = 1'b1;
      end
    end
  endtask

  bit          acc;
  bit          r_rst;
  bit          r_v;
  bit          r_cr;
  bit          r_g;
  int unsigned r_x;
  int unsigned r_y;
  int unsigned r_c;

  initial begin
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_color = '0;
    clear_req = 1'b0;
    fb_grant  = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);

    // Full clear with continuous grant, then a few idle running cycles.
    for (int i = 0; i < int'(TOTAL) + 3; i++) step(0, 0, 0, 0, 0, 0, 1, acc);

    // Single pixel, committed one cycle after acceptance.
    step(0, 1, 3, 5, 9'h1FF, 0, 1, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, acc);

    // Grant low: five offered, FIFO fills at four; then drain and take the fifth.
    for (int i = 0; i < 5; i++) step(0, 1, i + 1, 2, 9'h100 + i, 0, 0, acc);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 6, 2, 9'h105, 0, 1, acc);
      if (acc) break;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, acc);

    // Clear request with two queued pixels and no grant, then grant returns.
    step(0, 1, 7, 1, 9'h0F0, 0, 0, acc);
    step(0, 1, 8, 1, 9'h00F, 0, 0, acc);
    step(0, 0, 0, 0, 0, 1, 0, acc);
    for (int i = 0; i < 3; i++) step(0, 1, 9, 1, 9'h111, 0, 0, acc);
    for (int i = 0; i < int'(TOTAL) + 8; i++) step(0, 0, 0, 0, 0, 0, 1, acc);

    // Out-of-range pixels (clipped and counted only when clipping is built in).
    step(0, 1, H, 0, 9'h055, 0, 1, acc);
    step(0, 1, 0, V, 9'h0AA, 0, 1, acc);
    for (int i = 0; i < 300; i++) step(0, 1, H + (i % 40), i % (2 * V), i, 0, 1, acc);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1, acc);

    // Reset with three queued pixels: they must never be written.
    for (int i = 0; i < 3; i++) step(0, 1, i, 3, 9'h1C0 + i, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, 0, acc);
    for (int i = 0; i < int'(TOTAL) + 4; i++) step(0, 0, 0, 0, 0, 0, 1, acc);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      r_v   = ($urandom_range(0, 2) != 0);
      r_x   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, H - 1);
      r_y   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, V - 1);
      r_c   = $urandom_range(0, 511);
      r_cr  = ($urandom_range(0, 149) == 0);
      r_g   = ($urandom_range(0, 3) != 0);
      step(r_rst, r_v, r_x, r_y, r_c, r_cr, r_g, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
